// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, issues one instruction-memory read at a time and
// presents the returned word to the decoder through a valid/ready handshake.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_FAULT
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_squash;
  logic        r_fault;

  logic w_redirect_live;
  logic w_misaligned;

  // A faulted fetch unit ignores redirects; only reset brings it back.
  assign w_redirect_live = redirect & (r_state != ST_FAULT);
  assign w_misaligned    = |redirect_pc[1:0];

  assign imem_req    = (r_state == ST_REQ) & ~redirect;
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == ST_HOLD) & ~redirect;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign fetch_fault = r_fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_REQ;
      r_pc       <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_instr_pc <= '0;
      r_squash   <= 1'b0;
      r_fault    <= 1'b0;
    end else if (w_redirect_live) begin
      if (w_misaligned) begin
        r_fault <= 1'b1;
        r_state <= ST_FAULT;
      end else begin
        r_pc <= redirect_pc;
        case (r_state)
          ST_WAIT: begin
            // An ack arriving with the redirect is simply dropped; otherwise
            // remember to drop the one still in flight.
            if (imem_ack) begin
              r_squash <= 1'b0;
              r_state  <= ST_REQ;
            end else begin
              r_squash <= 1'b1;
            end
          end
          ST_HOLD: begin
            r_instr <= NOP_INSTR;
            r_state <= ST_REQ;
          end
          default: ;
        endcase
      end
    end else begin
      case (r_state)
        ST_REQ: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (imem_ack) begin
            if (r_squash) begin
              r_squash <= 1'b0;
              r_state  <= ST_REQ;
            end else begin
              r_instr    <= imem_rdata;
              r_instr_pc <= r_pc;
              r_pc       <= r_pc + 32'd4;
              r_state    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            r_instr <= NOP_INSTR;
            r_state <= ST_REQ;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
